// File: rtl/multicycle_processor.sv
// Multi-cycle MIPS-subset core sharing one memory port between instruction fetch and data.
// Each instruction walks FETCH -> DECODE -> EXECUTE [-> MEM] [-> WRITEBACK]; faults park in HALT.
module multicycle_processor #(
    parameter int ADDR_W      = 8,
    parameter int RESET_PC    = 0,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk_in,
    input  logic              clr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc_out,
    output logic              retire,
    output logic              halted,
    output logic              fault,
    output logic [2:0]        dbg_state
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_pc, r_maddr;
    logic [31:0]       r_ir, r_a, r_b, r_imm, r_result;
    logic [31:0]       r_regs [32];
    logic [31:0]       r_wait;
    logic              r_fault;

    logic [5:0]        w_op, w_funct;
    logic [4:0]        w_rs, w_rt, w_dest;
    logic              w_legal, w_funct_ok, w_access, w_timeout, w_wr_en;
    logic [ADDR_W-1:0] w_pc4, w_btarget, w_jtarget, w_eaddr;
    logic [31:0]       w_alu, w_wb;

    assign w_op       = r_ir[31:26];
    assign w_rs       = r_ir[25:21];
    assign w_rt       = r_ir[20:16];
    assign w_funct    = r_ir[5:0];
    assign w_pc4      = r_pc + ADDR_W'(4);
    assign w_btarget  = w_pc4 + ADDR_W'({r_imm[29:0], 2'b00});
    assign w_jtarget  = ADDR_W'({r_ir[25:0], 2'b00});
    assign w_eaddr    = ADDR_W'(r_a + r_imm);
    assign w_access   = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_timeout  = w_access && !mem_ack && (r_wait == 32'(ACK_TIMEOUT - 1));
    assign w_legal    = (w_op == OP_RTYPE) || (w_op == OP_J) || (w_op == OP_BEQ) ||
                        (w_op == OP_ADDI) || (w_op == OP_LW) || (w_op == OP_SW);
    assign w_funct_ok = (w_funct == 6'h20) || (w_funct == 6'h22) || (w_funct == 6'h24) ||
                        (w_funct == 6'h25) || (w_funct == 6'h2A);

    // An R-type with an unknown funct still retires, it just never writes the file.
    assign w_dest  = (w_op == OP_RTYPE) ? r_ir[15:11] : w_rt;
    assign w_wr_en = (w_dest != 5'd0) && !((w_op == OP_RTYPE) && !w_funct_ok);
    assign w_wb    = r_result;

    always_comb begin
        w_alu = r_a + r_imm;
        if (w_op == OP_RTYPE) begin
            case (w_funct)
                6'h20:   w_alu = r_a + r_b;
                6'h22:   w_alu = r_a - r_b;
                6'h24:   w_alu = r_a & r_b;
                6'h25:   w_alu = r_a | r_b;
                6'h2A:   w_alu = {31'd0, $signed(r_a) < $signed(r_b)};
                default: w_alu = '0;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ack)        w_next = S_DECODE;
                else if (w_timeout) w_next = S_HALT;
            end
            S_DECODE:  w_next = w_legal ? S_EXECUTE : S_HALT;
            S_EXECUTE: begin
                case (w_op)
                    OP_LW, OP_SW: w_next = S_MEM;
                    OP_BEQ, OP_J: w_next = S_FETCH;
                    default:      w_next = S_WRITEBACK;
                endcase
            end
            S_MEM: begin
                if (mem_ack)        w_next = (w_op == OP_LW) ? S_WRITEBACK : S_FETCH;
                else if (w_timeout) w_next = S_HALT;
            end
            S_WRITEBACK: w_next = S_FETCH;
            S_HALT:      w_next = S_HALT;
            default:     w_next = S_FETCH;
        endcase
    end

    // Bus outputs are masked by clr so nothing is requested or retired while reset is held.
    always_comb begin
        mem_req   = w_access && !clr;
        mem_we    = (r_state == S_MEM) && (w_op == OP_SW) && !clr;
        mem_addr  = '0;
        mem_wdata = '0;
        if (r_state == S_FETCH) mem_addr = {r_pc[ADDR_W-1:2], 2'b00};
        if (r_state == S_MEM) begin
            mem_addr = r_maddr;
            if (w_op == OP_SW) mem_wdata = r_b;
        end
        retire = !clr && (((r_state == S_EXECUTE) && ((w_op == OP_BEQ) || (w_op == OP_J))) ||
                          ((r_state == S_MEM) && (w_op == OP_SW) && mem_ack) ||
                          (r_state == S_WRITEBACK));
    end

    assign pc_out    = r_pc;
    assign halted    = (r_state == S_HALT);
    assign fault     = r_fault;
    assign dbg_state = r_state;

    always_ff @(posedge clk_in) begin
        if (clr) begin
            r_state  <= S_FETCH;
            r_pc     <= ADDR_W'(RESET_PC);
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_imm    <= '0;
            r_result <= '0;
            r_maddr  <= '0;
            r_wait   <= '0;
            r_fault  <= 1'b0;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            r_state <= w_next;
            if (w_access && !mem_ack && !w_timeout) r_wait <= r_wait + 32'd1;
            else                                    r_wait <= '0;
            // HALT is only ever entered on an illegal opcode or a bus timeout.
            if (w_next == S_HALT) r_fault <= 1'b1;
            case (r_state)
                S_FETCH: if (mem_ack) r_ir <= mem_rdata;
                S_DECODE: begin
                    r_a   <= r_regs[w_rs];
                    r_b   <= r_regs[w_rt];
                    r_imm <= {{16{r_ir[15]}}, r_ir[15:0]};
                end
                S_EXECUTE: begin
                    r_result <= w_alu;
                    r_maddr  <= {w_eaddr[ADDR_W-1:2], 2'b00};
                    if (w_op == OP_BEQ) r_pc <= (r_a == r_b) ? w_btarget : w_pc4;
                    if (w_op == OP_J)   r_pc <= w_jtarget;
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (w_op == OP_SW) r_pc     <= w_pc4;
                        else               r_result <= mem_rdata;
                    end
                end
                S_WRITEBACK: begin
                    r_pc <= w_pc4;
                    if (w_wr_en) r_regs[w_dest] <= w_wb;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_processor.sv
// Bench for multicycle_processor: ALU vector table, directed multi-cycle sequences,
// and random programs checked against an instruction-level model of the ISA.
`timescale 1ns/1ps
module tb_multicycle_processor;
  localparam int NWORDS = 64;
  localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

  logic        clk_in = 1'b0;
  logic        clr;
  logic        mem_req, mem_we, mem_ack;
  logic [7:0]  mem_addr, pc_out;
  logic [31:0] mem_wdata, mem_rdata;
  logic        retire, halted, fault;
  logic [2:0]  dbg_state;

  always #5 clk_in = ~clk_in;

  multicycle_processor #(.ADDR_W(8), .RESET_PC(0), .ACK_TIMEOUT(255)) dut (
    .clk_in(clk_in), .clr(clr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .pc_out(pc_out), .retire(retire), .halted(halted),
    .fault(fault), .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [NWORDS];
  logic [31:0] m_mem [NWORDS];
  logic [31:0] m_regs [32];
  int          cyc = 0;
  int          retire_q[$];
  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] exp_q[$];

  int          wait_n = 0;
  bit          rand_wait = 0;
  bit          no_ack = 0;
  bit          in_acc = 0;
  int          waited, target;
  logic [40:0] cap_bus;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int funct);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, funct[5:0]};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_j(int addr);
    logic [31:0] t;
    t = addr;
    return {6'h02, t[27:2]};
  endfunction

  // Memory responder: counts cycles, inserts wait states, serves reads/writes, checks bus stability.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk_in);
      if (clr) cyc = 0;
      else     cyc = cyc + 1;
      if (!mem_req) begin
        mem_ack = 1'b0;
        in_acc = 0;
      end else begin
        if (!in_acc) begin
          in_acc = 1;
          waited = 0;
          target = rand_wait ? int'($urandom_range(0, 2)) : wait_n;
          cap_bus = {mem_we, mem_addr, mem_wdata};
        end else begin
          check("bus_stable_while_req", {mem_we, mem_addr, mem_wdata}, cap_bus);
        end
        if (!no_ack && waited >= target) begin
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr[7:2]];
          if (mem_we) begin
            mem[mem_addr[7:2]] = mem_wdata;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
          end
          in_acc = 0;
        end else begin
          mem_ack = 1'b0;
          waited++;
        end
      end
    end
  end

  // Retire is sampled after the responder has settled mem_ack for the cycle.
  initial forever begin
    @(negedge clk_in);
    #2;
    if (retire) retire_q.push_back(cyc);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_mem();
    for (int i = 0; i < NWORDS; i++) mem[i] = '0;
  endtask

  task automatic do_reset();
    @(posedge clk_in); #1;
    clr = 1'b1;
    retire_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    @(posedge clk_in); #1;
    clr = 1'b0;
  endtask

  task automatic step_to(input int c);
    for (int i = 0; i < c + 4 && cyc < c; i++) begin
      @(negedge clk_in); #1;
    end
  endtask

  task automatic run_until_halt(input int max_cyc, output int hc);
    hc = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk_in); #1;
      if (halted) begin
        hc = cyc;
        break;
      end
    end
    if (hc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL halt_timeout: no halt within %0d cycles", max_cyc);
    end
  endtask

  // Instruction-level model: returns instructions retired before halting, -1 if it never halts.
  function automatic int run_model();
    int pc, ret;
    logic [31:0] ins, simm, a, b, v, ea;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    bit ok;
    pc = 0;
    ret = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    for (int step = 0; step < 1000; step++) begin
      ins = m_mem[pc / 4];
      op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
      simm = {{16{ins[15]}}, ins[15:0]};
      a = m_regs[rs];
      b = m_regs[rt];
      ok = 1;
      v = '0;
      case (op)
        6'h00: begin
          case (fn)
            6'h20: v = a + b;
            6'h22: v = a - b;
            6'h24: v = a & b;
            6'h25: v = a | b;
            6'h2A: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: ok = 0;
          endcase
          if (ok && rd != 0) m_regs[rd] = v;
          pc = (pc + 4) & 255;
        end
        6'h08: begin
          if (rt != 0) m_regs[rt] = a + simm;
          pc = (pc + 4) & 255;
        end
        6'h23: begin
          ea = a + simm;
          if (rt != 0) m_regs[rt] = m_mem[ea[7:2]];
          pc = (pc + 4) & 255;
        end
        6'h2B: begin
          ea = a + simm;
          m_mem[ea[7:2]] = b;
          pc = (pc + 4) & 255;
        end
        6'h04: pc = (a == b) ? ((pc + 4 + int'(simm) * 4) & 255) : ((pc + 4) & 255);
        6'h02: pc = (int'(ins[25:0]) * 4) & 255;
        default: return ret;
      endcase
      ret++;
    end
    return -1;
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          funct;
    int          rd;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs [10];
  int       hc, bad, exp_ret, kind, rs, rt, rd, k;
  bit       found;
  int       fl [6];

  initial begin
    clr = 1'b1;
    clear_mem();
    mem[0] = ILLEGAL;

    // Reset state while clr is held, then the first fetch right after release.
    repeat (2) @(posedge clk_in);
    @(negedge clk_in); #1;
    check("reset_mem_req", mem_req, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_retire", retire, 0);
    check("reset_halted", halted, 0);
    check("reset_fault", fault, 0);
    check("reset_pc", pc_out, 8'h00);
    @(posedge clk_in); #1;
    clr = 1'b0;
    @(negedge clk_in); #1;
    check("first_fetch_req", mem_req, 1);
    check("first_fetch_addr", mem_addr, 8'h00);
    check("first_fetch_we", mem_we, 0);

    // addi/addi/add, jump over data words, sw then lw of the sum.
    clear_mem();
    mem[0]  = enc_i(8, 0, 1, 5);
    mem[1]  = enc_i(8, 0, 2, -3);
    mem[2]  = enc_r(1, 2, 3, 32'h20);
    mem[3]  = enc_j(32'h20);
    mem[8]  = enc_i(32'h2B, 0, 3, 32'h10);
    mem[9]  = enc_i(32'h23, 0, 4, 32'h10);
    mem[10] = enc_i(32'h2B, 0, 4, 32'h14);
    mem[11] = ILLEGAL;
    exp_q = '{4, 8, 12, 15, 19, 24, 28};
    do_reset();
    run_until_halt(100, hc);
    check("prog1_halt_cycle", hc, 31);
    check("prog1_retire_count", retire_q.size(), exp_q.size());
    while (exp_q.size() > 0 && retire_q.size() > 0)
      check("prog1_retire_cycle", retire_q.pop_front(), exp_q.pop_front());
    check("prog1_write_count", wr_addr_q.size(), 2);
    if (wr_addr_q.size() == 2) begin
      check("sw_addr", wr_addr_q[0], 8'h10);
      check("sw_wdata", wr_data_q[0], 32'd2);
      check("lw_result_stored", wr_data_q[1], 32'd2);
    end
    check("prog1_fault", fault, 1);

    // beq $1,$1,-1 at 0x20 spins with a 3-cycle period.
    clear_mem();
    mem[0] = enc_j(32'h20);
    mem[8] = enc_i(4, 1, 1, -1);
    do_reset();
    for (int c = 4; c <= 13; c += 3) begin
      step_to(c);
      check("beq_loop_pc", pc_out, 8'h20);
    end
    exp_q = '{3, 6, 9, 12};
    check("beq_loop_retires", retire_q.size(), 4);
    while (exp_q.size() > 0 && retire_q.size() > 0)
      check("beq_loop_retire_cycle", retire_q.pop_front(), exp_q.pop_front());

    // beq not taken falls through to PC+4.
    clear_mem();
    mem[0] = enc_i(8, 0, 2, 1);
    mem[1] = enc_j(32'h20);
    mem[8] = enc_i(4, 1, 2, 5);
    mem[9] = ILLEGAL;
    do_reset();
    step_to(11);
    check("beq_not_taken_pc", pc_out, 8'h24);
    run_until_halt(50, hc);
    check("beq_not_taken_halt_cycle", hc, 13);

    // Three fetch wait states stretch an R-type to 7 cycles.
    clear_mem();
    mem[0] = enc_r(1, 2, 3, 32'h20);
    mem[1] = ILLEGAL;
    wait_n = 3;
    do_reset();
    run_until_halt(100, hc);
    check("rtype_wait_retire_count", retire_q.size(), 1);
    if (retire_q.size() > 0) check("rtype_wait_latency", retire_q[0], 7);
    wait_n = 0;

    // No ack at all: timeout fault, then HALT is absorbing.
    no_ack = 1;
    do_reset();
    run_until_halt(400, hc);
    check("timeout_halt_cycle", hc, 256);
    check("timeout_fault", fault, 1);
    check("timeout_req_dropped", mem_req, 0);
    no_ack = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in); #1;
      if (mem_req || retire || !halted || !fault) bad++;
    end
    check("halt_absorbing", bad, 0);

    // Illegal opcode 0x3F after one addi.
    clear_mem();
    mem[0] = enc_i(8, 0, 1, 9);
    mem[1] = ILLEGAL | 32'h0022_FFFF;
    do_reset();
    run_until_halt(50, hc);
    check("illegal_halt_cycle", hc, 7);
    check("illegal_fault", fault, 1);
    check("illegal_retires", retire_q.size(), 1);
    check("illegal_no_writes", wr_addr_q.size(), 0);

    // clr while an lw is waiting in MEM.
    clear_mem();
    mem[0]  = enc_i(32'h23, 0, 1, 32'hC0);
    mem[1]  = enc_i(32'h2B, 0, 1, 32'hC4);
    mem[2]  = ILLEGAL;
    mem[48] = 32'h0000_1234;
    wait_n = 2;
    do_reset();
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_in); #1;
      if (mem_req && !mem_we && mem_addr == 8'hC0) begin
        found = 1;
        break;
      end
    end
    check("clr_mid_lw_reached", found, 1);
    @(posedge clk_in); #1;
    clr = 1'b1;
    @(negedge clk_in); #1;
    check("clr_mid_lw_req_low", mem_req, 0);
    @(posedge clk_in); #1;
    check("clr_mid_lw_pc", pc_out, 8'h00);
    check("clr_mid_lw_no_retire", retire_q.size(), 0);
    clr = 1'b0;
    @(negedge clk_in); #1;
    check("clr_mid_lw_refetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h00});
    run_until_halt(100, hc);
    check("clr_mid_lw_rerun", mem[49], 32'h0000_1234);
    wait_n = 0;

    // ALU vectors: load two operands, apply one R-type, store the destination.
    vecs[0] = '{32'd5,        32'd7,        32'h20, 3, 32'd12};
    vecs[1] = '{32'h7FFFFFFF, 32'd1,        32'h20, 3, 32'h80000000};
    vecs[2] = '{32'd3,        32'd5,        32'h22, 3, 32'hFFFFFFFE};
    vecs[3] = '{32'hF0F01234, 32'h0FF0FF00, 32'h24, 3, 32'h00F01200};
    vecs[4] = '{32'hF0F00000, 32'h00001234, 32'h25, 3, 32'hF0F01234};
    vecs[5] = '{32'hFFFFFFFF, 32'd1,        32'h2A, 3, 32'd1};
    vecs[6] = '{32'd1,        32'hFFFFFFFF, 32'h2A, 3, 32'd0};
    vecs[7] = '{32'h80000000, 32'h7FFFFFFF, 32'h2A, 3, 32'd1};
    vecs[8] = '{32'd9,        32'd4,        32'h21, 3, 32'd0};
    vecs[9] = '{32'd5,        32'd5,        32'h20, 0, 32'd0};
    for (int v = 0; v < 10; v++) begin
      clear_mem();
      mem[0]  = enc_i(32'h23, 0, 1, 32'hC0);
      mem[1]  = enc_i(32'h23, 0, 2, 32'hC4);
      mem[2]  = enc_r(1, 2, vecs[v].rd, vecs[v].funct);
      mem[3]  = enc_i(32'h2B, 0, vecs[v].rd, 32'hC8);
      mem[4]  = ILLEGAL;
      mem[48] = vecs[v].a;
      mem[49] = vecs[v].b;
      mem[50] = 32'hDEADBEEF;
      do_reset();
      run_until_halt(100, hc);
      check($sformatf("alu_vec%0d_result", v), mem[50], vecs[v].exp);
      check($sformatf("alu_vec%0d_halt_cycle", v), hc, 21);
      check($sformatf("alu_vec%0d_retires", v), retire_q.size(), 4);
    end

    // Random programs with random wait states against the instruction-level model.
    fl = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A, 32'h21};
    rand_wait = 1;
    for (int it = 0; it < 6; it++) begin
      clear_mem();
      for (int idx = 0; idx < 24; idx++) begin
        kind = $urandom_range(0, 5);
        rs = $urandom_range(0, 8);
        rt = $urandom_range(1, 8);
        rd = $urandom_range(0, 8);
        k  = $urandom_range(0, 7);
        case (kind)
          0: mem[idx] = enc_r(rs, rt, rd, fl[$urandom_range(0, 5)]);
          1: mem[idx] = enc_i(8, rs, rt, int'($urandom_range(0, 65535)));
          2: mem[idx] = enc_i(32'h23, 0, rt, 32'hC0 + 4 * k);
          3: mem[idx] = enc_i(32'h2B, 0, rt, 32'hC0 + 4 * k);
          4: mem[idx] = enc_i(4, rs, rt, int'($urandom_range(0, 1)));
          default: mem[idx] = enc_j((idx + 1 + int'($urandom_range(0, 1))) * 4);
        endcase
      end
      for (int i = 0; i < 8; i++) mem[24 + i] = enc_i(32'h2B, 0, i + 1, 32'hE0 + 4 * i);
      mem[32] = ILLEGAL;
      for (int i = 48; i < 56; i++) mem[i] = $urandom;
      for (int i = 0; i < NWORDS; i++) m_mem[i] = mem[i];
      exp_ret = run_model();
      do_reset();
      run_until_halt(3000, hc);
      check($sformatf("rand%0d_retires", it), retire_q.size(), exp_ret);
      check($sformatf("rand%0d_fault", it), fault, 1);
      for (int i = 48; i < NWORDS; i++)
        check($sformatf("rand%0d_mem[%0d]", it, i), mem[i], m_mem[i]);
    end
    rand_wait = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_processor.md
MULTICYCLE_PROCESSOR -- requirements
Module: multicycle_processor

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8: byte-address width of the PC and the memory bus.
REQ-002 The block SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 The block SHALL have parameter ACK_TIMEOUT, default 255: maximum wait cycles for mem_ack before halting on a fault.
REQ-004 The block SHALL have port clk_in, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port mem_req, output, 1 bit: memory access request.
REQ-007 The block SHALL have port mem_we, output, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have port mem_addr, output, ADDR_W bits: word-aligned byte address, bits [1:0] always 00.
REQ-009 The block SHALL have port mem_wdata, output, 32 bits: store data.
REQ-010 The block SHALL have port mem_rdata, input, 32 bits: read data, valid in the cycle mem_ack=1.
REQ-011 The block SHALL have port mem_ack, input, 1 bit: access complete.
REQ-012 The block SHALL have port pc_out, output, ADDR_W bits: address of the current instruction.
REQ-013 The block SHALL have port retire, output, 1 bit: one-cycle pulse when an instruction completes.
REQ-014 The block SHALL have port halted, output, 1 bit: core stopped.
REQ-015 The block SHALL have port fault, output, 1 bit: set together with halted on an illegal opcode or an ack timeout.

Function
REQ-016 The core SHALL be a multi-cycle MIPS subset sharing one memory port for instructions and data, with FSM states FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
REQ-017 The core SHALL support: R-type (op 0x00) add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; lw 0x23; sw 0x2B; beq 0x04; addi 0x08; j 0x02.
REQ-018 R-type with an unsupported funct SHALL execute as a nop: no register write, retire pulses, PC+4.
REQ-019 Any other opcode SHALL cause a transition to HALT with halted=1 and fault=1, and no architectural state change.
REQ-020 FETCH SHALL assert mem_req=1, mem_we=0, mem_addr=PC; on mem_ack=1 it SHALL latch IR and go to DECODE.
REQ-021 DECODE SHALL latch rs/rt register values and the sign-extended imm16, then go to EXECUTE.
REQ-022 EXECUTE SHALL resolve each instruction class as follows:
- R-type/addi -> WRITEBACK.
- lw/sw -> MEM, with address = (rs + simm)[ADDR_W-1:0] and bits [1:0] forced to 00.
- beq: PC <= (PC+4)+(simm<<2) if rs==rt, else PC+4; retire; -> FETCH.
- j: PC <= {imm26,2'b00}[ADDR_W-1:0]; retire; -> FETCH.
REQ-023 MEM SHALL hold mem_req=1 until ack.
- sw: mem_we=1, mem_wdata=rt; on ack retire, PC+4, -> FETCH.
- lw: on ack latch mem_rdata, -> WRITEBACK.
REQ-024 WRITEBACK SHALL write the destination (rd for R-type, rt for addi/lw), retire, PC+4, -> FETCH.
REQ-025 Latency with mem_ack the same cycle as mem_req SHALL be: beq/j 3 cycles; R-type/addi/sw 4; lw 5. Each extra wait cycle adds 1.
REQ-026 While mem_req=1, mem_addr, mem_we and mem_wdata SHALL stay stable.
- mem_req SHALL drop in the cycle after the ack.
- mem_ack SHALL be ignored while mem_req=0.
REQ-027 ACK_TIMEOUT consecutive wait cycles without ack SHALL drop mem_req and enter HALT with fault=1.
REQ-028 Arithmetic SHALL be 32-bit two's complement wrapping; overflow raises no exception.
- slt is signed.
- PC arithmetic wraps modulo 2^ADDR_W.
REQ-029 Register file: 32x32; $0 SHALL read 0, and writes to $0 SHALL be discarded.
REQ-030 HALT SHALL be absorbing until clr, with mem_req=0 and retire=0.

Reset
REQ-031 With clr=1 at a rising edge, the core SHALL, from any state (including mid-access or HALT):
- set state=FETCH, PC=RESET_PC;
- clear all 32 registers and IR;
- set mem_req=0, mem_we=0, retire=0, halted=0, fault=0;
- ignore mem_ack.
REQ-032 The first fetch SHALL issue in the first cycle after clr falls.

Verification
REQ-033 addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 with 0-wait memory -> $3=2; retire pulses at cycles 4, 8, 12 after reset.
REQ-034 sw $3,0x10($0); lw $4,0x10($0) -> write cycle mem_addr=0x10, wdata=2; $4=2; lw takes 5 cycles.
REQ-035 beq $1,$1,-1 at PC=0x20 -> PC returns to 0x20 every 3 cycles; beq $1,$2 not taken -> PC=0x24.
REQ-036 mem_ack held low 3 cycles on fetch -> mem_addr/mem_req stable throughout; R-type latency 7; no ack for 255 cycles -> halted=1, fault=1.
REQ-037 Opcode 0x3F -> halted=fault=1 and registers unchanged; clr mid-MEM of an lw -> mem_req=0 and PC=RESET_PC next cycle, load discarded.
REQ-038 add $0,$1,$1 -> $0 still reads 0; add 0x7FFFFFFF+1 -> 0x80000000, no fault.
